// File: rtl/snd_dma_fifo.sv
// ---------------------------------------------------------------------------
// snd_dma_fifo
//
// Shifter-side receiver for sound DMA word loads. Words strobed in by the MCU
// (sload_n) are buffered in a small FIFO. They are then unpacked into signed
// 8-bit PCM samples at the programmed sample rate and driven to the audio
// mixer. Everything is synchronous to clk32.
//
// Ports:
//   clk32    in   system clock (32 MHz)
//   reset    in   synchronous, active-high reset
//   sndon    in   sound DMA enable (level); dropping it flushes the block
//   sload_n  in   MCU load strobe, active low; its falling edge loads din
//   din      in   16-bit data word, valid while sload_n is low
//   rate     in   sample rate: 0=6258, 1=12517, 2=25033, 3=50066 Hz
//   mono     in   1 = two mono samples per word (high byte first);
//                 0 = stereo, L = din[15:8], R = din[7:0]
//   sreq     out  registered sound data request to the MCU
//   audio_l  out  signed left sample
//   audio_r  out  signed right sample
//   level    out  FIFO occupancy in words
//   ovf      out  sticky: a load arrived while the FIFO was full
//   unf      out  one-cycle pulse: a sample tick found the FIFO empty
//
// Load handshake:
//   sreq is the "ready" side and says that at least SREQ_SLACK words are free
//   after this cycle's push/pop. The extra slack absorbs the MCU's latching
//   latency. The falling edge of sload_n is the "valid" side. Exactly one
//   word is taken per falling edge, no matter how long sload_n stays low.
//   din is captured in the same cycle the edge is seen. A load that finds
//   the FIFO full, with no pop in the same cycle, is dropped and sets ovf.
//   Loads while sndon=0 are ignored entirely.
// ---------------------------------------------------------------------------
module snd_dma_fifo #(
  parameter int DEPTH      = 4,    // FIFO depth in words, power of two, 2..16
  parameter int DIV50K     = 640,  // clk32 cycles per tick at 50066 Hz
  parameter int SREQ_SLACK = 2     // free words required to raise sreq
) (
  input  logic                     clk32,
  input  logic                     reset,
  input  logic                     sndon,
  input  logic                     sload_n,
  input  logic [15:0]              din,
  input  logic [1:0]               rate,
  input  logic                     mono,
  output logic                     sreq,
  output logic [7:0]               audio_l,
  output logic [7:0]               audio_r,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW      = $clog2(DEPTH);
  localparam int DIV_MAX = DIV50K * 8;
  localparam int DW      = $clog2(DIV_MAX + 1);

  localparam logic [AW:0] LVL_FULL     = (AW + 1)'(DEPTH);
  // Highest occupancy at which sreq may still be asserted.
  localparam logic [AW:0] SREQ_MAX_LVL = (AW + 1)'(DEPTH - SREQ_SLACK);

  // Storage and pointers
  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Input history registers used for edge/change detection
  logic           sload_q;
  logic           sndon_q;
  logic [1:0]     rate_q;
  logic           mono_q;

  // Sample-rate divider and mono byte select (1 = high byte next)
  logic [DW-1:0]  div_cnt;
  logic [DW-1:0]  div_term;
  logic           hsel;

  // Per-cycle control
  logic           load_ev;
  logic           empty;
  logic           full;
  logic           rate_chg;
  logic           tick;
  logic           pop;
  logic           push;
  logic           drop;
  logic [AW:0]    level_nxt;
  logic           sreq_nxt;
  logic [15:0]    head;
  logic [7:0]     mono_sample;

  // Terminal count of the divider for each rate (50 kHz period doubled per
  // step down in rate).
  always_comb begin
    div_term = '0;
    case (rate)
      2'd0:    div_term = DW'(DIV50K * 8 - 1);
      2'd1:    div_term = DW'(DIV50K * 4 - 1);
      2'd2:    div_term = DW'(DIV50K * 2 - 1);
      default: div_term = DW'(DIV50K - 1);
    endcase
  end

  always_comb begin
    load_ev     = sload_q & ~sload_n;
    empty       = (level == '0);
    full        = (level == LVL_FULL);
    rate_chg    = (rate != rate_q);
    // A rate change restarts the divider, so no tick can fire that cycle.
    tick        = sndon & ~rate_chg & (div_cnt == div_term);
    head        = mem[rd_ptr];
    mono_sample = hsel ? head[15:8] : head[7:0];
    // In mono a word is retired only after its low byte has been played.
    pop         = tick & ~empty & (~mono | ~hsel);
    // The pop frees the slot first, so a load into a full FIFO is accepted
    // when a pop happens in the same cycle.
    push        = sndon & load_ev & (~full | pop);
    drop        = sndon & load_ev & full & ~pop;
  end

  always_comb begin
    level_nxt = level;
    if (!sndon) begin
      level_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + 1'b1;
        2'b01:   level_nxt = level - 1'b1;
        default: level_nxt = level;
      endcase
    end
    sreq_nxt = sndon & (level_nxt <= SREQ_MAX_LVL);
  end

  // FIFO storage: no reset needed, occupancy is tracked by level/pointers.
  always_ff @(posedge clk32) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      sload_q <= 1'b1;
      sndon_q <= 1'b0;
      rate_q  <= rate;
      mono_q  <= mono;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      sreq    <= 1'b0;
      audio_l <= '0;
      audio_r <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      div_cnt <= '0;
      hsel    <= 1'b1;
    end else begin
      sload_q <= sload_n;
      sndon_q <= sndon;
      rate_q  <= rate;
      mono_q  <= mono;
      level   <= level_nxt;
      sreq    <= sreq_nxt;
      unf     <= tick & empty;

      if (!sndon) begin
        // Disabled: flush the FIFO, silence the outputs, park the divider.
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        audio_l <= '0;
        audio_r <= '0;
        div_cnt <= '0;
        hsel    <= 1'b1;
      end else begin
        if (rate_chg || (div_cnt == div_term)) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end

        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end

        // An empty tick leaves the outputs and the byte select untouched.
        if (tick && !empty) begin
          if (mono) begin
            audio_l <= mono_sample;
            audio_r <= mono_sample;
            hsel    <= ~hsel;
          end else begin
            audio_l <= head[15:8];
            audio_r <= head[7:0];
          end
        end

        // Switching mono/stereo restarts the next word at its high byte.
        if (mono != mono_q) begin
          hsel <= 1'b1;
        end
      end

      // drop requires sndon=1, so it can never collide with the clear.
      if (drop) begin
        ovf <= 1'b1;
      end else if (sndon_q && !sndon) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snd_dma_fifo.sv
// ---------------------------------------------------------------------------
// tb_snd_dma_fifo
//
// Directed bench for snd_dma_fifo (DEPTH=4, DIV50K=640, SREQ_SLACK=2).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected samples are queued as words are loaded. They are popped and
// compared at each sample tick. Tick times come from a count of clk32 edges
// since sndon went high, and that count is checked against the
// programmed-rate period.
// ---------------------------------------------------------------------------
module tb_snd_dma_fifo;

  logic        clk32 = 1'b0;
  logic        reset;
  logic        sndon;
  logic        sload_n;
  logic [15:0] din;
  logic [1:0]  rate;
  logic        mono;
  logic        sreq;
  logic [7:0]  audio_l;
  logic [7:0]  audio_r;
  logic [2:0]  level;
  logic        ovf;
  logic        unf;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] last_audio = '0;
  int          on_cyc     = 0;
  int          cur_div    = 640;

  snd_dma_fifo #(.DEPTH(4), .DIV50K(640), .SREQ_SLACK(2)) dut (
    .clk32   (clk32),
    .reset   (reset),
    .sndon   (sndon),
    .sload_n (sload_n),
    .din     (din),
    .rate    (rate),
    .mono    (mono),
    .sreq    (sreq),
    .audio_l (audio_l),
    .audio_r (audio_r),
    .level   (level),
    .ovf     (ovf),
    .unf     (unf)
  );

  // Clock and enable-relative cycle count
  always #5 clk32 = ~clk32;

  always @(posedge clk32) begin
    if (sndon) on_cyc <= on_cyc + 1;
    else       on_cyc <= 0;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Checking and driver tasks
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] w);
    if (mono) begin
      exp_q.push_back({w[15:8], w[15:8]});
      exp_q.push_back({w[7:0], w[7:0]});
    end else begin
      exp_q.push_back(w);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    din     = w;
    sload_n = 1'b0;
    @(negedge clk32);
    sload_n = 1'b1;
    @(negedge clk32);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk32);
      n++;
    end while (!(on_cyc != 0 && (on_cyc % cur_div) == 0) && n < 6000);
    check_eq("tick_wait", 32'(n < 6000), 1);
  endtask

  task automatic tick_check(input string tag);
    logic [15:0] e;
    wait_tick();
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unf"}, 32'(unf), 1);
      check_eq({tag, "_hold"}, {audio_l, audio_r}, last_audio);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_audio"}, {audio_l, audio_r}, e);
      check_eq({tag, "_nounf"}, 32'(unf), 0);
      last_audio = e;
    end
  endtask

  task automatic sound_off();
    sndon = 1'b0;
    @(negedge clk32);
    exp_q.delete();
    last_audio = '0;
  endtask

  // Stimulus
  initial begin
    int n;
    reset   = 1'b1;
    sndon   = 1'b0;
    sload_n = 1'b1;
    din     = '0;
    rate    = 2'd3;
    mono    = 1'b0;
    repeat (4) @(negedge clk32);

    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_sreq", 32'(sreq), 0);
    check_eq("rst_audio", {audio_l, audio_r}, 0);
    check_eq("rst_ovf", 32'(ovf), 0);
    check_eq("rst_unf", 32'(unf), 0);
    reset = 1'b0;
    @(negedge clk32);

    // Enable with nothing loaded: request raised, empty tick underflows
    cur_div = 640;
    sndon   = 1'b1;
    repeat (2) @(negedge clk32);
    check_eq("on_sreq", 32'(sreq), 1);
    check_eq("on_level", 32'(level), 0);
    tick_check("empty_tick");
    @(negedge clk32);
    check_eq("unf_pulse_end", 32'(unf), 0);

    // Stereo word at 50 kHz
    push_exp(16'h7F80);
    load_word(16'h7F80);
    check_eq("st_level1", 32'(level), 1);
    check_eq("st_sreq1", 32'(sreq), 1);
    tick_check("st_tick");
    check_eq("st_level0", 32'(level), 0);
    check_eq("st_sreq0", 32'(sreq), 1);

    // Mono word at 6.25 kHz
    sound_off();
    rate = 2'd0;
    mono = 1'b1;
    cur_div = 5120;
    repeat (2) @(negedge clk32);
    sndon = 1'b1;
    push_exp(16'h1234);
    load_word(16'h1234);
    tick_check("mono_hi");
    check_eq("mono_hi_level", 32'(level), 1);
    tick_check("mono_lo");
    check_eq("mono_lo_level", 32'(level), 0);

    // Fill to full; sreq falls once fewer than two words are free
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      w = {4'(2 * i + 1), 4'(2 * i + 1), 4'(2 * i + 2), 4'(2 * i + 2)};
      push_exp(w);
      load_word(w);
      check_eq($sformatf("fill_level%0d", i), 32'(level), 32'(i + 1));
      check_eq($sformatf("fill_sreq%0d", i), 32'(sreq), 32'(i < 2));
    end
    check_eq("fill_ovf", 32'(ovf), 0);

    // High byte of the head word: no pop while full
    tick_check("full_hi");
    check_eq("full_hi_level", 32'(level), 4);

    // Load edge in the same cycle as a pop, then sload_n held low
    n = 0;
    while ((on_cyc % cur_div) != cur_div - 1 && n < 6000) begin
      @(negedge clk32);
      n++;
    end
    check_eq("pre_tick_wait", 32'(n < 6000), 1);
    din     = 16'h99AA;
    sload_n = 1'b0;
    push_exp(16'h99AA);
    tick_check("coinc_pop");
    check_eq("coinc_level", 32'(level), 4);
    check_eq("coinc_ovf", 32'(ovf), 0);
    repeat (19) @(negedge clk32);
    check_eq("longlow_level", 32'(level), 4);
    check_eq("longlow_ovf", 32'(ovf), 0);
    sload_n = 1'b1;
    @(negedge clk32);

    // Load while full with no pop is dropped
    load_word(16'hBBCC);
    check_eq("ovf_set", 32'(ovf), 1);
    check_eq("ovf_level", 32'(level), 4);

    tick_check("drain_hi");
    check_eq("drain_hi_level", 32'(level), 4);
    tick_check("drain_lo");
    check_eq("drain_lo_level", 32'(level), 3);
    check_eq("drain_ovf", 32'(ovf), 1);

    // Disable flushes everything; later loads are ignored
    sound_off();
    check_eq("off_level", 32'(level), 0);
    check_eq("off_audio", {audio_l, audio_r}, 0);
    check_eq("off_ovf", 32'(ovf), 0);
    check_eq("off_sreq", 32'(sreq), 0);
    load_word(16'hDEAD);
    check_eq("off_load_level", 32'(level), 0);
    check_eq("off_load_ovf", 32'(ovf), 0);

    // Re-enable in stereo at 50 kHz; a long-low strobe loads once
    mono    = 1'b0;
    rate    = 2'd3;
    cur_div = 640;
    repeat (2) @(negedge clk32);
    sndon   = 1'b1;
    din     = 16'hA55A;
    sload_n = 1'b0;
    push_exp(16'hA55A);
    repeat (20) @(negedge clk32);
    check_eq("re_longlow_level", 32'(level), 1);
    sload_n = 1'b1;
    tick_check("re_tick");
    check_eq("re_level", 32'(level), 0);
    check_eq("re_sreq", 32'(sreq), 1);
    check_eq("exp_q_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
